fifo_readout: RTL

Clocked drain engine at the read end of the latch-based pulse-controlled FIFO. It watches the FIFO empty flag and generates active-low read_n pulses. It captures each popped word and serializes it off chip on a single wire as: start bit, data bits, computed parity, stop bit. The FIFO does not store parity, so parity is generated here.

---
 rtl/fifo_readout.sv | 113 +++++++++++
 1 files changed

// File: rtl/fifo_readout.sv
// fifo_readout: pops the FIFO with registered read_n pulses and sends each word on tx_out as start, data LSB-first, odd parity, stop; reports tx_busy and frame_count
module fifo_readout #(
  parameter int FIFO_WIDTH   = 63,
  parameter int CLKS_PER_BIT = 4,
  parameter int READ_PULSE   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [FIFO_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  input  logic                  tx_enable,
  output logic                  read_n,
  output logic                  tx_out,
  output logic                  tx_busy,
  output logic [15:0]           frame_count
);
  localparam int CW = $clog2((CLKS_PER_BIT > READ_PULSE ? CLKS_PER_BIT : READ_PULSE) + 1);
  localparam int BW = $clog2(FIFO_WIDTH + 1);
  typedef enum logic [2:0] {IDLE, READ, CAPTURE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_d;
  logic [1:0] sync;
  logic [CW-1:0] cnt, cnt_d;
  logic [BW-1:0] bit_cnt, bit_d;
  logic [FIFO_WIDTH-1:0] sh, sh_d;
  logic par, par_d, rd_d, tx_d, last;
  logic [15:0] fc_d;
  logic empty_s;
  assign empty_s = sync[1];
  assign tx_busy = state != IDLE;
  assign last = cnt == CW'(CLKS_PER_BIT - 1);
  always_comb begin
    state_d = state;
    cnt_d = cnt + CW'(1);
    bit_d = bit_cnt;
    sh_d = sh;
    par_d = par;
    rd_d = read_n;
    tx_d = tx_out;
    fc_d = frame_count;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (tx_enable && !empty_s) begin
          state_d = READ;
          rd_d = 1'b0;
        end
      end
      READ: if (cnt == CW'(READ_PULSE - 1)) begin
        state_d = CAPTURE;
        rd_d = 1'b1;
        cnt_d = '0;
      end
      CAPTURE: begin
        state_d = START;
        sh_d = fifo_data;
        par_d = ~^fifo_data;
        tx_d = 1'b0;
        cnt_d = '0;
      end
      START: if (last) begin
        state_d = DATA;
        tx_d = sh[0];
        bit_d = '0;
        cnt_d = '0;
      end
      DATA: if (last) begin
        cnt_d = '0;
        bit_d = bit_cnt + BW'(1);
        if (bit_cnt == BW'(FIFO_WIDTH - 1)) begin
          state_d = PARITY;
          tx_d = par;
        end else begin
          sh_d = sh >> 1;
          tx_d = sh_d[0];
        end
      end
      PARITY: if (last) begin
        state_d = STOP;
        tx_d = 1'b1;
        cnt_d = '0;
      end
      STOP: if (last) begin
        state_d = IDLE;
        fc_d = frame_count + 16'd1;
        cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      sync <= 2'b11;
      cnt <= '0;
      bit_cnt <= '0;
      sh <= '0;
      par <= 1'b0;
      read_n <= 1'b1;
      tx_out <= 1'b1;
      frame_count <= '0;
    end else begin
      state <= state_d;
      sync <= {sync[0], fifo_empty};
      cnt <= cnt_d;
      bit_cnt <= bit_d;
      sh <= sh_d;
      par <= par_d;
      read_n <= rd_d;
      tx_out <= tx_d;
      frame_count <= fc_d;
    end
  end
endmodule
